i2c_req_arbiter: RTL and testbench
==================================

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one I2C_Controller.
REQ-002 Parameter MAX_RETRY, default 3: maximum re-issues of one transaction after a NACK.
REQ-003 Parameter TIMEOUT_CYC, default 65535: iCLK cycles allowed in ISSUE for END to rise.
REQ-004 Port iCLK, input, 1: system clock; sole clock of the block.
REQ-005 Port iRST, input, 1: reset, synchronous, active-high.
REQ-006 Port iREQ, input, N_REQ: one-cycle request strobe per requester.
REQ-007 Port iDATA, input, 24*N_REQ: packed {slave_addr, sub_addr, data}; requester i occupies bits [24*i+23:24*i].
REQ-008 Port oPEND, output, N_REQ: request latched and not yet granted.
REQ-009 Port oDONE, output, N_REQ: one-cycle completion pulse for the granted requester.
REQ-010 Port oERR, output, N_REQ: failure flag, valid only in the oDONE cycle.
REQ-011 Port oBUSY, output, 1: high whenever the state is not IDLE.
REQ-012 Port oGRANT, output, clog2(N_REQ): index of the requester being serviced.
REQ-013 Port oI2C_DATA, output, 24: word presented to the I2C_Controller.
REQ-014 Port oI2C_GO, output, 1: GO to the I2C_Controller.
REQ-015 Port iI2C_END, input, 1: END from the controller (slow-clock domain).
REQ-016 Port iI2C_ACK, input, 1: ACK from the controller (slow-clock domain); 0 = acknowledged, 1 = NACK.

Function
REQ-017 iI2C_END and iI2C_ACK shall each pass through a 2-flop synchronizer; only the synchronized END_s and ACK_s are used.
REQ-018 iREQ[i]=1 shall set pend[i] and capture iDATA slice i into buffer i on the same edge.
REQ-019 iREQ[i] while pend[i]=1 shall be ignored: buffer and pend are unchanged.
REQ-020 States: IDLE, ISSUE, EVAL, RELEASE, DONE.
REQ-021 IDLE with any pend set: pick the first set bit searching round-robin from last_grant+1 (mod N_REQ); load oGRANT and oI2C_DATA from that buffer; clear its pend; clear the retry count; go to ISSUE.
REQ-022 When the grant clear and a new iREQ for the same index fall on the same edge, the set wins; oI2C_DATA keeps the old word.
REQ-023 ISSUE: oI2C_GO=1; go to EVAL when END_s=1; after TIMEOUT_CYC cycles without END_s, set err and go to RELEASE.
REQ-024 EVAL: ACK_s=0 clears err; ACK_s=1 with retry<MAX_RETRY increments retry and sets the redo flag; ACK_s=1 with retry=MAX_RETRY sets err. Always go to RELEASE.
REQ-025 RELEASE: oI2C_GO=0; wait for END_s=0. Then go to ISSUE if redo is set (clear redo), else go to DONE.
REQ-026 DONE: oDONE[oGRANT]=1 and oERR[oGRANT]=err for exactly one cycle; update last_grant; go to IDLE.
REQ-027 Grant latency: an iREQ strobe seen in IDLE with no other pend set raises oI2C_GO 2 cycles later.
REQ-028 Back-to-back service: a new grant may occur in the IDLE cycle right after DONE.
REQ-029 Timeouts are not retried.
REQ-030 oI2C_DATA shall stay stable from the grant until the next grant.

Reset
REQ-031 iRST=1 shall, on the next edge, force IDLE and clear pend, buffers, oDONE, oERR, oBUSY, oI2C_GO, oI2C_DATA, oGRANT, the retry count, err, redo and both synchronizers.
REQ-032 Reset shall set last_grant=N_REQ-1 so requester 0 wins first.
REQ-033 Reset mid-transaction shall drop GO with no oDONE pulse.

Verification
REQ-034 Single request: iREQ=4'b0001 with iDATA[23:0]=24'h34_0E01, controller model ACKs -> oI2C_GO rises 2 cycles later, oI2C_DATA=24'h340E01, then oDONE=4'b0001 with oERR=0.
REQ-035 Round-robin: iREQ=4'b1111 in one cycle -> grants in order 0,1,2,3; then a new pulse on 0 and 2 -> grants 0 then 2.
REQ-036 NACK retry: model NACKs 2 times then ACKs -> oI2C_GO pulses 3 times, oERR=0; model NACKs 4 times -> 4 GO pulses, oERR=1.
REQ-037 Timeout: model never raises END, TIMEOUT_CYC=100 -> GO falls after 100 cycles, oDONE with oERR=1, 1 GO pulse.
REQ-038 Collision: iREQ[1] on the grant edge of requester 1 -> oPEND[1]=1 afterwards, oI2C_DATA holds the old word, and requester 1 is serviced again.
REQ-039 Reset during ISSUE -> oI2C_GO=0, oPEND=0, oBUSY=0 next cycle, no oDONE pulse.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter sharing one I2C_Controller among
// N_REQ requesters, with NACK retry and END timeout.
module i2c_req_arbiter #(
   parameter int N_REQ       = 4,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 65535,
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic [N_REQ-1:0]    iREQ,
   input  logic [24*N_REQ-1:0] iDATA,
   output logic [N_REQ-1:0]    oPEND,
   output logic [N_REQ-1:0]    oDONE,
   output logic [N_REQ-1:0]    oERR,
   output logic                oBUSY,
   output logic [GW-1:0]       oGRANT,
   output logic [23:0]         oI2C_DATA,
   output logic                oI2C_GO,
   input  logic                iI2C_END,
   input  logic                iI2C_ACK
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, ISSUE, EVAL, RELEASE, DONE
   } stateT;

   stateT            state, stateN;
   logic             endS1, endS2, ackS1, ackS2;
   logic [N_REQ-1:0] pend;
   logic [23:0]      bufQ [N_REQ];
   logic [GW-1:0]    lastGrant, lastN;
   logic [GW-1:0]    pickIdx, cand;
   logic             pickVld, grantNow;
   logic [RW-1:0]    retry, retryN;
   logic [TW-1:0]    timer, timerN;
   logic             err, errN, redo, redoN;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         endS1 <= 1'b0;
         endS2 <= 1'b0;
         ackS1 <= 1'b0;
         ackS2 <= 1'b0;
      end else begin
         endS1 <= iI2C_END;
         endS2 <= endS1;
         ackS1 <= iI2C_ACK;
         ackS2 <= ackS1;
      end
   end

   // Search starts one past the last serviced index.
   always_comb begin
      pickVld = 1'b0;
      pickIdx = '0;
      cand    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = GW'((int'(lastGrant) + k) % N_REQ);
         if (!pickVld && pend[cand]) begin
            pickVld = 1'b1;
            pickIdx = cand;
         end
      end
   end

   assign grantNow = (state == IDLE) && pickVld;
   assign oPEND    = pend;

   // A new strobe on the index being granted re-arms it.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         pend <= '0;
         for (int i = 0; i < N_REQ; i++) bufQ[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (iREQ[i] && (!pend[i] ||
                (grantNow && pickIdx == GW'(i)))) begin
               pend[i] <= 1'b1;
               bufQ[i] <= iDATA[24*i +: 24];
            end else if (grantNow && pickIdx == GW'(i)) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= IDLE;
         retry     <= '0;
         timer     <= '0;
         err       <= 1'b0;
         redo      <= 1'b0;
         lastGrant <= GW'(N_REQ - 1);
         oGRANT    <= '0;
         oI2C_DATA <= '0;
      end else begin
         state     <= stateN;
         retry     <= retryN;
         timer     <= timerN;
         err       <= errN;
         redo      <= redoN;
         lastGrant <= lastN;
         if (grantNow) begin
            oGRANT    <= pickIdx;
            oI2C_DATA <= bufQ[pickIdx];
         end
      end
   end

   always_comb begin
      stateN = state;
      retryN = retry;
      timerN = timer;
      errN   = err;
      redoN  = redo;
      lastN  = lastGrant;
      unique case (state)
         IDLE: begin
            if (pickVld) begin
               stateN = ISSUE;
               retryN = '0;
               timerN = '0;
               errN   = 1'b0;
               redoN  = 1'b0;
            end
         end
         ISSUE: begin
            if (endS2) begin
               stateN = EVAL;
            end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
               errN   = 1'b1;
               stateN = RELEASE;
            end else begin
               timerN = timer + 1'b1;
            end
         end
         EVAL: begin
            stateN = RELEASE;
            if (!ackS2) begin
               errN = 1'b0;
            end else if (retry < RW'(MAX_RETRY)) begin
               retryN = retry + 1'b1;
               redoN  = 1'b1;
            end else begin
               errN = 1'b1;
            end
         end
         RELEASE: begin
            if (!endS2) begin
               if (redo) begin
                  redoN  = 1'b0;
                  timerN = '0;
                  stateN = ISSUE;
               end else begin
                  stateN = DONE;
               end
            end
         end
         DONE: begin
            lastN  = oGRANT;
            stateN = IDLE;
         end
         default: stateN = IDLE;
      endcase
   end

   assign oBUSY   = (state != IDLE);
   assign oI2C_GO = (state == ISSUE);

   always_comb begin
      oDONE = '0;
      oERR  = '0;
      if (state == DONE) begin
         oDONE[oGRANT] = 1'b1;
         oERR[oGRANT]  = err;
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed and randomized checks of i2c_req_arbiter
// against a transaction-level reference model and a controller model.
`timescale 1ns/1ps
module tb_i2c_req_arbiter;
   localparam int N  = 4;
   localparam int MR = 3;
   localparam int TO = 100;

   logic           iCLK = 1'b0;
   logic           iRST;
   logic [N-1:0]   iREQ;
   logic [24*N-1:0] iDATA;
   logic [N-1:0]   oPEND, oDONE, oERR;
   logic           oBUSY;
   logic [1:0]     oGRANT;
   logic [23:0]    oI2C_DATA;
   logic           oI2C_GO;
   logic           iI2C_END, iI2C_ACK;

   always #5 iCLK = ~iCLK;

   i2c_req_arbiter #(
      .N_REQ(N), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iDATA(iDATA),
      .oPEND(oPEND), .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY),
      .oGRANT(oGRANT), .oI2C_DATA(oI2C_DATA), .oI2C_GO(oI2C_GO),
      .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK)
   );

   int nChecks = 0;
   int nFail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N-1:0]    ePend, eDone, eErr, sReq;
   logic [23:0]     mBuf [N];
   logic [23:0]     eData;
   logic [24*N-1:0] sData;
   int              mLast, eGrant;
   logic            eGo, eBusy, sRst;
   logic            s1, s2, a1, a2, endS, ackS;

   task automatic mResetState();
      ePend = '0;
      for (int i = 0; i < N; i++) mBuf[i] = '0;
      mLast = N - 1;
      eGrant = 0; eData = '0;
      eGo = 1'b0; eBusy = 1'b0;
      eDone = '0; eErr = '0;
      s1 = 1'b0; s2 = 1'b0; a1 = 1'b0; a2 = 1'b0;
   endtask

   // One clock edge: inputs as seen just before it, and the
   // synchronized END/ACK values the design acts upon at it.
   task automatic mTick();
      @(posedge iCLK);
      sReq = iREQ; sData = iDATA; sRst = iRST;
      endS = s2; ackS = a2;
      s2 = s1; s1 = iI2C_END;
      a2 = a1; a1 = iI2C_ACK;
   endtask

   task automatic mReqs(input int clr);
      logic [N-1:0] old;
      old = ePend;
      for (int i = 0; i < N; i++) begin
         if (sReq[i] && (!old[i] || clr == i)) begin
            ePend[i] = 1'b1;
            mBuf[i]  = sData[24*i +: 24];
         end else if (clr == i) begin
            ePend[i] = 1'b0;
         end
      end
   endtask

   function automatic int rrPick(input logic [N-1:0] p, input int last);
      for (int k = 1; k <= N; k++)
         if (p[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic mServe(input int g);
      int   n, retries;
      logic tmo, redo, err;
      retries = 0; err = 1'b0;
      forever begin
         n = 0; tmo = 1'b0; redo = 1'b0;
         forever begin
            mTick();
            if (sRst) begin mResetState(); return; end
            mReqs(-1);
            if (endS) break;
            n++;
            if (n == TO) begin tmo = 1'b1; break; end
         end
         eGo = 1'b0;
         if (tmo) begin
            err = 1'b1;
         end else begin
            mTick();
            if (sRst) begin mResetState(); return; end
            mReqs(-1);
            if (!ackS) err = 1'b0;
            else if (retries < MR) begin retries++; redo = 1'b1; end
            else err = 1'b1;
         end
         do begin
            mTick();
            if (sRst) begin mResetState(); return; end
            mReqs(-1);
         end while (endS);
         if (redo) begin eGo = 1'b1; continue; end
         eDone = '0; eDone[g] = 1'b1;
         eErr  = '0; eErr[g]  = err;
         mTick();
         if (sRst) begin mResetState(); return; end
         mReqs(-1);
         eDone = '0; eErr = '0; eBusy = 1'b0; mLast = g;
         return;
      end
   endtask

   initial begin
      int g;
      mResetState();
      forever begin
         mTick();
         if (sRst) begin mResetState(); continue; end
         g = rrPick(ePend, mLast);
         if (g >= 0) begin
            eGrant = g; eData = mBuf[g];
            mReqs(g);
            eGo = 1'b1; eBusy = 1'b1;
            mServe(g);
         end else begin
            mReqs(-1);
         end
      end
   end

   initial forever begin
      @(posedge iCLK);
      #1;
      check("m_pend", oPEND, ePend);
      check("m_busy", oBUSY, eBusy);
      check("m_go",   oI2C_GO, eGo);
      check("m_grant", oGRANT, eGrant);
      check("m_data", oI2C_DATA, eData);
      check("m_done", oDONE, eDone);
      check("m_err",  oERR, eErr);
   end

   // ---------------- controller model ----------------
   int   respQ[$];
   logic ctlRand;
   int   ctlPh, ctlResp, ctlDly;
   int   goPulses = 0, goLen = 0;
   logic goPrev = 1'b0;

   function automatic int nextResp();
      int r;
      if (respQ.size() > 0) return respQ.pop_front();
      if (!ctlRand) return 0;
      r = $urandom_range(0, 99);
      if (r < 75) return 0;
      if (r < 95) return 1;
      return 2;
   endfunction

   initial begin
      iI2C_END = 1'b0; iI2C_ACK = 1'b0; ctlPh = 0;
      forever begin
         @(negedge iCLK);
         if (iRST) begin
            iI2C_END = 1'b0; iI2C_ACK = 1'b0; ctlPh = 0;
         end else begin
            case (ctlPh)
               0: if (oI2C_GO) begin
                     ctlResp = nextResp();
                     ctlDly = $urandom_range(0, 4);
                     ctlPh = 1;
                  end
               1: if (!oI2C_GO) ctlPh = 0;
                  else if (ctlResp != 2) begin
                     if (ctlDly == 0) begin
                        iI2C_END = 1'b1;
                        iI2C_ACK = (ctlResp == 1);
                        ctlPh = 2;
                     end else ctlDly--;
                  end
               2: if (!oI2C_GO) begin
                     ctlDly = $urandom_range(0, 3);
                     ctlPh = 3;
                  end
               default: if (ctlDly == 0) begin
                     iI2C_END = 1'b0; iI2C_ACK = 1'b0; ctlPh = 0;
                  end else ctlDly--;
            endcase
         end
      end
   end

   initial forever begin
      @(negedge iCLK);
      if (oI2C_GO && !goPrev) begin goPulses++; goLen = 0; end
      if (oI2C_GO) goLen++;
      goPrev = oI2C_GO;
   end

   // ---------------- stimulus ----------------
   logic [N-1:0] d, e;
   int p0;

   task automatic waitDone(output logic [N-1:0] dd, output logic [N-1:0] ee);
      dd = '0; ee = '0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge iCLK);
         if (oDONE != '0) begin dd = oDONE; ee = oERR; return; end
      end
      nChecks++; nFail++;
      $display("FAIL done_wait: no oDONE within 3000 cycles");
   endtask

   task automatic waitGo();
      for (int i = 0; i < 20; i++) begin
         @(negedge iCLK);
         if (oI2C_GO) return;
      end
      nChecks++; nFail++;
      $display("FAIL go_wait: oI2C_GO not seen within 20 cycles");
   endtask

   task automatic doRst();
      iRST = 1'b1;
      @(negedge iCLK);
      iRST = 1'b0;
   endtask

   initial begin
      iRST = 1'b1; iREQ = '0; iDATA = '0; ctlRand = 1'b0;
      repeat (3) @(negedge iCLK);
      iRST = 1'b0;
      check("rst_busy", oBUSY, 0);
      check("rst_pend", oPEND, 0);
      check("rst_go", oI2C_GO, 0);
      check("rst_grant", oGRANT, 0);

      // single request, latency and data
      iREQ = 4'b0001; iDATA[23:0] = 24'h340E01;
      @(negedge iCLK);
      iREQ = '0;
      check("lat_go_early", oI2C_GO, 0);
      check("lat_pend", oPEND, 4'b0001);
      @(negedge iCLK);
      check("lat_go", oI2C_GO, 1);
      check("lat_data", oI2C_DATA, 24'h340E01);
      waitDone(d, e);
      check("single_done", d, 4'b0001);
      check("single_err", e, 0);

      // round-robin order
      doRst();
      iREQ = 4'b1111;
      iDATA = {24'hDD0003, 24'hCC0002, 24'hBB0001, 24'hAA0000};
      @(negedge iCLK);
      iREQ = '0;
      for (int k = 0; k < 4; k++) begin
         waitDone(d, e);
         check("rr_order", d, 32'(1 << k));
      end
      iREQ = 4'b0101;
      @(negedge iCLK);
      iREQ = '0;
      waitDone(d, e);
      check("rr_second0", d, 4'b0001);
      waitDone(d, e);
      check("rr_second2", d, 4'b0100);

      // NACK retry
      respQ = '{1, 1, 0};
      p0 = goPulses;
      iREQ = 4'b0010;
      @(negedge iCLK);
      iREQ = '0;
      waitDone(d, e);
      check("retry_pulses", goPulses - p0, 3);
      check("retry_err", e, 0);
      respQ = '{1, 1, 1, 1};
      p0 = goPulses;
      iREQ = 4'b0010;
      @(negedge iCLK);
      iREQ = '0;
      waitDone(d, e);
      check("nack_pulses", goPulses - p0, 4);
      check("nack_err", e, 4'b0010);

      // timeout
      respQ = '{2};
      p0 = goPulses;
      iREQ = 4'b1000;
      @(negedge iCLK);
      iREQ = '0;
      waitDone(d, e);
      check("tmo_pulses", goPulses - p0, 1);
      check("tmo_len", goLen, TO);
      check("tmo_err", e, 4'b1000);

      // collision on the grant edge
      doRst();
      iREQ = 4'b0010; iDATA[47:24] = 24'h111111;
      @(negedge iCLK);
      iDATA[47:24] = 24'h222222;
      @(negedge iCLK);
      iREQ = '0;
      check("col_pend", oPEND, 4'b0010);
      check("col_data_old", oI2C_DATA, 24'h111111);
      check("col_grant", oGRANT, 1);
      waitDone(d, e);
      check("col_done1", d, 4'b0010);
      waitGo();
      check("col_data_new", oI2C_DATA, 24'h222222);
      waitDone(d, e);
      check("col_done2", d, 4'b0010);

      // reset during ISSUE
      doRst();
      iREQ = 4'b0101;
      @(negedge iCLK);
      iREQ = '0;
      waitGo();
      iRST = 1'b1;
      @(negedge iCLK);
      iRST = 1'b0;
      check("mid_rst_go", oI2C_GO, 0);
      check("mid_rst_pend", oPEND, 0);
      check("mid_rst_busy", oBUSY, 0);
      repeat (10) begin
         @(negedge iCLK);
         check("mid_rst_nodone", oDONE, 0);
      end

      // randomized traffic
      ctlRand = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++)
            iREQ[i] = ($urandom_range(0, 7) == 0);
         iDATA = {$urandom, $urandom, $urandom};
         iRST = ($urandom_range(0, 599) == 0);
         @(negedge iCLK);
      end
      iREQ = '0; iRST = 1'b0;
      repeat (800) @(negedge iCLK);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFail);
      $finish;
   end

endmodule
